// File: rtl/Common.sv
// Common: state enumeration for the MLP training sequencer.
package Common;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        TRAIN   = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } trainer_state_t;

endpackage

// File: rtl/FixedPoint.sv
// FixedPoint: signed Q8.8 fixed-point type shared by the MLP datapath,
// with saturating add/subtract helpers.
package FixedPoint;

    localparam int SFP_W = 16;

    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE     = 16'sh0100;
    localparam sfp SFP_MAX = 16'sh7fff;
    localparam sfp SFP_MIN = 16'sh8000;

    // Add with one guard bit; clamp to the rails when the sign overflows.
    function automatic sfp sfp_add(input sfp a, input sfp b);
        logic [SFP_W:0] s;
        s = {a[SFP_W-1], a} + {b[SFP_W-1], b};
        if (s[SFP_W] != s[SFP_W-1]) begin
            sfp_add = s[SFP_W] ? SFP_MIN : SFP_MAX;
        end else begin
            sfp_add = sfp'(s[SFP_W-1:0]);
        end
    endfunction

    // Subtract with one guard bit; clamp to the rails when the sign overflows.
    function automatic sfp sfp_sub(input sfp a, input sfp b);
        logic [SFP_W:0] s;
        s = {a[SFP_W-1], a} - {b[SFP_W-1], b};
        if (s[SFP_W] != s[SFP_W-1]) begin
            sfp_sub = s[SFP_W] ? SFP_MIN : SFP_MAX;
        end else begin
            sfp_sub = sfp'(s[SFP_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/mlp_trainer_pkg.sv
// mlp_trainer_pkg: trainer-local constants (plain state encodings for the
// FSM register) and a saturating absolute-value helper for the loss path.
package mlp_trainer_pkg;

    import FixedPoint::*;
    import Common::*;

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_APPLY   = APPLY;
    localparam logic [2:0] ST_TRAIN   = TRAIN;
    localparam logic [2:0] ST_ADVANCE = ADVANCE;
    localparam logic [2:0] ST_DONE    = DONE;

    // |x|, with the most negative value mapped to SFP_MAX.
    function automatic sfp sfp_abs(input sfp x);
        if (x == SFP_MIN) begin
            sfp_abs = SFP_MAX;
        end else if (x[SFP_W-1]) begin
            sfp_abs = -x;
        end else begin
            sfp_abs = x;
        end
    endfunction

endpackage

// File: rtl/mlp_sample_mem.sv
// mlp_sample_mem: training-sample store, synchronous write and combinational
// read. Deliberately has no reset so loaded samples survive a trainer abort.
module mlp_sample_mem #(
    parameter int width  = 48,
    parameter int depth  = 4,
    parameter int addr_w = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [width-1:0]  wr_data,
    input  logic [addr_w-1:0] rd_addr,
    output logic [width-1:0]  rd_data
);

    logic [width-1:0] mem_q [depth];

    // Store one sample per write-enabled edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mlp_trainer.sv
// mlp_trainer: sequences stored samples through an external MLP for a number
// of epochs: settle the forward pass, pulse training for one cycle, capture
// the prediction, then advance to the next sample/epoch.
// Optional feature: define MLP_TRAINER_LOSS_EN to accumulate the per-epoch
// L1 loss into epoch_loss; otherwise epoch_loss is tied to zero.
module mlp_trainer
    import FixedPoint::*;
    import Common::*;
    import mlp_trainer_pkg::*;
#(
    parameter int inputs        = 2,
    parameter int outputs       = 1,
    parameter int depth         = 4,
    parameter int settle_cycles = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(depth)-1:0]   wr_addr,
    input  logic [inputs*SFP_W-1:0]    wr_values,
    input  logic [outputs*SFP_W-1:0]   wr_expected,
    input  logic [15:0]                num_samples,
    input  logic [15:0]                num_epochs,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [inputs*SFP_W-1:0]    mlp_values,
    output logic [outputs*SFP_W-1:0]   mlp_expected,
    output logic                       mlp_training,
    input  logic [outputs*SFP_W-1:0]   mlp_prediction,
    output logic [15:0]                sample_index,
    output logic [15:0]                epoch_count,
    output logic                       result_valid,
    output logic [outputs*SFP_W-1:0]   result_prediction,
    output logic [SFP_W-1:0]           epoch_loss
);

    localparam int          ADDR_W      = $clog2(depth);
    localparam int          MEM_W       = (inputs + outputs) * SFP_W;
    localparam logic [15:0] DEPTH16     = 16'(depth);
    localparam logic [15:0] SETTLE_LAST = 16'(settle_cycles - 1);

    logic [2:0]                 state_q, state_d;
    logic [15:0]                settle_q, settle_d;
    logic [15:0]                sample_index_q, sample_index_d;
    logic [15:0]                epoch_count_q, epoch_count_d;
    logic [15:0]                n_q, n_d;
    logic [15:0]                e_q, e_d;
    logic [inputs*SFP_W-1:0]    mlp_values_q, mlp_values_d;
    logic [outputs*SFP_W-1:0]   mlp_expected_q, mlp_expected_d;
    logic [outputs*SFP_W-1:0]   result_prediction_q, result_prediction_d;

    logic             mem_wr;
    logic [MEM_W-1:0] rd_data;
    logic             last_sample;

    // Memory is only writable while idle so a run sees a frozen sample set.
    assign mem_wr = wr_en && (state_q == ST_IDLE);

    // The read address is the index being entered, so operands are ready to
    // latch on the same edge that moves the FSM into APPLY.
    mlp_sample_mem #(
        .width  (MEM_W),
        .depth  (depth),
        .addr_w (ADDR_W)
    ) u_sample_mem (
        .clk     (clk),
        .wr_en   (mem_wr),
        .wr_addr (wr_addr),
        .wr_data ({wr_values, wr_expected}),
        .rd_addr (sample_index_d[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign last_sample = (sample_index_q + 16'd1) >= n_q;

    // Sequencer: next state, settle counter, sample/epoch bookkeeping.
    always_comb begin
        state_d             = state_q;
        settle_d            = settle_q;
        sample_index_d      = sample_index_q;
        epoch_count_d       = epoch_count_q;
        n_d                 = n_q;
        e_d                 = e_q;
        result_prediction_d = result_prediction_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sample_index_d = '0;
                    epoch_count_d  = '0;
                    settle_d       = '0;
                    n_d            = (num_samples > DEPTH16) ? DEPTH16 : num_samples;
                    e_d            = num_epochs;
                    if (num_samples == 16'd0 || num_epochs == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_TRAIN;
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            ST_TRAIN: begin
                result_prediction_d = mlp_prediction;
                state_d             = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                settle_d = '0;
                if (!last_sample) begin
                    sample_index_d = sample_index_q + 16'd1;
                    state_d        = ST_APPLY;
                end else begin
                    sample_index_d = '0;
                    epoch_count_d  = epoch_count_q + 16'd1;
                    if ((epoch_count_q + 16'd1) == e_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the sample operands once on entry to APPLY; they then stay put
    // through TRAIN because memory cannot change while busy.
    always_comb begin
        mlp_values_d   = mlp_values_q;
        mlp_expected_d = mlp_expected_q;
        if (state_d == ST_APPLY && state_q != ST_APPLY) begin
            mlp_values_d   = rd_data[MEM_W-1 -: inputs*SFP_W];
            mlp_expected_d = rd_data[outputs*SFP_W-1:0];
        end
    end

    // Sequencer and operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            settle_q            <= '0;
            sample_index_q      <= '0;
            epoch_count_q       <= '0;
            n_q                 <= '0;
            e_q                 <= '0;
            mlp_values_q        <= '0;
            mlp_expected_q      <= '0;
            result_prediction_q <= '0;
        end else begin
            state_q             <= state_d;
            settle_q            <= settle_d;
            sample_index_q      <= sample_index_d;
            epoch_count_q       <= epoch_count_d;
            n_q                 <= n_d;
            e_q                 <= e_d;
            mlp_values_q        <= mlp_values_d;
            mlp_expected_q      <= mlp_expected_d;
            result_prediction_q <= result_prediction_d;
        end
    end

`ifdef MLP_TRAINER_LOSS_EN
    sfp loss_acc_q, loss_acc_d;
    sfp epoch_loss_q, epoch_loss_d;
    sfp sample_err;

    // L1 error of the current sample, summed over all outputs.
    always_comb begin
        sample_err = '0;
        for (int i = 0; i < outputs; i++) begin
            sample_err = sfp_add(sample_err,
                sfp_abs(sfp_sub(sfp'(mlp_prediction[i*SFP_W +: SFP_W]),
                                sfp'(mlp_expected_q[i*SFP_W +: SFP_W]))));
        end
    end

    // Accumulate per trained sample; publish and clear at each epoch boundary.
    always_comb begin
        loss_acc_d   = loss_acc_q;
        epoch_loss_d = epoch_loss_q;
        if (state_q == ST_IDLE && start) begin
            loss_acc_d = '0;
        end else if (state_q == ST_TRAIN) begin
            loss_acc_d = sfp_add(loss_acc_q, sample_err);
        end else if (state_q == ST_ADVANCE && last_sample) begin
            epoch_loss_d = loss_acc_q;
            loss_acc_d   = '0;
        end
    end

    // Loss registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_acc_q   <= '0;
            epoch_loss_q <= '0;
        end else begin
            loss_acc_q   <= loss_acc_d;
            epoch_loss_q <= epoch_loss_d;
        end
    end

    assign epoch_loss = epoch_loss_q;
`else
    assign epoch_loss = '0;
`endif

    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);
    assign mlp_training      = (state_q == ST_TRAIN);
    assign result_valid      = (state_q == ST_ADVANCE);
    assign mlp_values        = mlp_values_q;
    assign mlp_expected      = mlp_expected_q;
    assign sample_index      = sample_index_q;
    assign epoch_count       = epoch_count_q;
    assign result_prediction = result_prediction_q;

endmodule

// File: tb/tb_mlp_trainer.sv
// tb_mlp_trainer: scoreboard bench for mlp_trainer with a stub MLP.
// Stimulus queues expected results and done times; a negedge monitor pops
// and compares them whenever the trainer presents result_valid or done.
module tb_mlp_trainer;

    localparam int          INPUTS  = 2;
    localparam int          OUTPUTS = 1;
    localparam int          DEPTH   = 4;
    localparam int          SETTLE  = 2;
    localparam logic [15:0] ONE     = 16'h0100;
    localparam logic [15:0] HALF    = 16'h0080;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_values;
    logic [15:0] wr_expected;
    logic [15:0] num_samples;
    logic [15:0] num_epochs;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] mlp_values;
    logic [15:0] mlp_expected;
    logic        mlp_training;
    logic [15:0] mlp_prediction;
    logic [15:0] sample_index;
    logic [15:0] epoch_count;
    logic        result_valid;
    logic [15:0] result_prediction;
    logic [15:0] epoch_loss;

    typedef struct {
        logic [15:0] idx;
        logic [15:0] ep;
        logic [15:0] pred;
    } exp_t;

    exp_t        res_q[$];
    int          done_q[$];
    int          cyc            = 0;
    int          checks         = 0;
    int          fails          = 0;
    int          train_seen     = 0;
    int          train_expected = 0;
    int          stub_mode      = 0;
    logic [15:0] tbl_v0 [DEPTH];
    logic [15:0] tbl_v1 [DEPTH];
    logic [15:0] tbl_e  [DEPTH];

    mlp_trainer #(
        .inputs        (INPUTS),
        .outputs       (OUTPUTS),
        .depth         (DEPTH),
        .settle_cycles (SETTLE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_values         (wr_values),
        .wr_expected       (wr_expected),
        .num_samples       (num_samples),
        .num_epochs        (num_epochs),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .mlp_values        (mlp_values),
        .mlp_expected      (mlp_expected),
        .mlp_training      (mlp_training),
        .mlp_prediction    (mlp_prediction),
        .sample_index      (sample_index),
        .epoch_count       (epoch_count),
        .result_valid      (result_valid),
        .result_prediction (result_prediction),
        .epoch_loss        (epoch_loss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub MLP: a fixed mix of the operands, or a constant 0.5.
    always_comb begin
        if (stub_mode != 0) begin
            mlp_prediction = HALF;
        end else begin
            mlp_prediction = mlp_values[15:0] + (mlp_values[31:16] << 1) + (mlp_expected << 2);
        end
    end

    function automatic logic [15:0] modelPred(input int i);
        if (stub_mode != 0) return HALF;
        return tbl_v0[i] + (tbl_v1[i] << 1) + (tbl_e[i] << 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: got no/extra event, expected the opposite", name);
    endtask

    // Monitor: pop and compare on every result_valid and done cycle.
    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (!rst) begin
            if (mlp_training) train_seen++;
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    failNow("unexpected_result_valid");
                end else begin
                    e = res_q.pop_front();
                    checkOutput("result_index", 32'(sample_index), 32'(e.idx));
                    checkOutput("result_epoch", 32'(epoch_count), 32'(e.ep));
                    checkOutput("result_pred", 32'(result_prediction), 32'(e.pred));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    failNow("unexpected_done");
                end else begin
                    t = done_q.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(t));
                end
            end
        end
    end

    task automatic writeSample(input int i, input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] e);
        @(negedge clk);
        wr_en       = 1'b1;
        wr_addr     = 2'(i);
        wr_values   = {v1, v0};
        wr_expected = e;
        tbl_v0[i]   = v0;
        tbl_v1[i]   = v1;
        tbl_e[i]    = e;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] ns, input logic [15:0] ne);
        int   n;
        exp_t e;
        @(negedge clk);
        n = (int'(ns) > DEPTH) ? DEPTH : int'(ns);
        if (ns == 16'd0 || ne == 16'd0) begin
            done_q.push_back(cyc + 1);
        end else begin
            for (int ep = 0; ep < int'(ne); ep++) begin
                for (int i = 0; i < n; i++) begin
                    e.idx  = 16'(i);
                    e.ep   = 16'(ep);
                    e.pred = modelPred(i);
                    res_q.push_back(e);
                end
            end
            done_q.push_back(cyc + 1 + n * int'(ne) * (SETTLE + 2));
            train_expected += n * int'(ne);
        end
        num_samples = ns;
        num_epochs  = ne;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (done_q.size() != 0) begin
            failNow("done_timeout");
            done_q.delete();
            res_q.delete();
        end
    endtask

    task automatic checkRunEnd(input logic [15:0] ep_exp);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("sample_index_held", 32'(sample_index), 32'd0);
        checkOutput("epoch_count_held", 32'(epoch_count), 32'(ep_exp));
        checkOutput("results_drained", 32'(res_q.size()), 32'd0);
        checkOutput("training_pulses", 32'(train_seen), 32'(train_expected));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_values   = '0;
        wr_expected = '0;
        num_samples = '0;
        num_epochs  = '0;
        start       = 1'b0;

        // Reset state, observed before any clock edge.
        #2 rst = 1'b1;
        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_training", 32'(mlp_training), 32'd0);
        checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_sample_index", 32'(sample_index), 32'd0);
        checkOutput("rst_epoch_count", 32'(epoch_count), 32'd0);
        checkOutput("rst_result_pred", 32'(result_prediction), 32'd0);
        checkOutput("rst_epoch_loss", 32'(epoch_loss), 32'd0);
        checkOutput("rst_mlp_values", mlp_values, 32'd0);
        checkOutput("rst_mlp_expected", 32'(mlp_expected), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // XOR sample set.
        writeSample(0, 16'h0000, 16'h0000, 16'h0000);
        writeSample(1, 16'h0000, ONE,      ONE);
        writeSample(2, ONE,      16'h0000, ONE);
        writeSample(3, ONE,      ONE,      16'h0000);

        $display("[TB] XOR run, N=4 E=1");
        applyStimulus(16'd4, 16'd1);
        waitDone(100);
        checkRunEnd(16'd1);
`ifndef MLP_TRAINER_LOSS_EN
        checkOutput("epoch_loss_tied", 32'(epoch_loss), 32'd0);
`endif

        $display("[TB] clamped run, num_samples=9 E=2");
        applyStimulus(16'd9, 16'd2);
        waitDone(200);
        checkRunEnd(16'd2);

        $display("[TB] zero-epoch run");
        applyStimulus(16'd4, 16'd0);
        waitDone(10);
        checkRunEnd(16'd0);

        $display("[TB] writes and start while busy");
        applyStimulus(16'd4, 16'd1);
        wr_en       = 1'b1;
        wr_addr     = 2'd1;
        wr_values   = 32'hdead_beef;
        wr_expected = 16'h1234;
        num_samples = 16'd1;
        num_epochs  = 16'd7;
        start       = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        checkOutput("busy_during_run", 32'(busy), 32'd1);
        waitDone(100);
        checkRunEnd(16'd1);

        $display("[TB] reset during TRAIN");
        @(negedge clk);
        num_samples = 16'd4;
        num_epochs  = 16'd1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (mlp_training) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) failNow("train_timeout");
        else train_expected++;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_training", 32'(mlp_training), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_done", 32'(done), 32'd0);
        checkOutput("async_rst_index", 32'(sample_index), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("train_after_abort", 32'(train_seen), 32'(train_expected));
        applyStimulus(16'd4, 16'd1);
        waitDone(100);
        checkRunEnd(16'd1);

`ifdef MLP_TRAINER_LOSS_EN
        $display("[TB] loss run, prediction 0.5 for expected 1.0");
        stub_mode = 1;
        writeSample(0, 16'h0040, 16'h0000, ONE);
        writeSample(1, 16'h0000, 16'h0040, ONE);
        applyStimulus(16'd2, 16'd1);
        waitDone(100);
        checkRunEnd(16'd1);
        checkOutput("epoch_loss", 32'(epoch_loss), 32'(ONE));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mlp_trainer.md
MLP_TRAINER -- requirements
Module: mlp_trainer

Interface
REQ-001 SHALL have parameter inputs, default 2, the number of MLP input values per sample.
REQ-002 SHALL have parameter outputs, default 1, the number of MLP expected/prediction values per sample.
REQ-003 SHALL have parameter depth, default 4, the number of sample-memory entries.
REQ-004 SHALL have parameter settle_cycles, default 2, the forward-pass settle time in cycles (minimum 1).
REQ-005 SHALL have ports clk (in, 1, single clock) and rst (in, 1, asynchronous active-high reset).
REQ-006 SHALL have wr_en (in, 1), wr_addr (in, $clog2(depth)), wr_values (in, sfp[inputs]) and wr_expected (in, sfp[outputs]) forming the sample-memory write port.
REQ-007 SHALL have num_samples and num_epochs (in, 16 each), plus start (in, 1), busy (out, 1) and done (out, 1, one-cycle pulse).
REQ-008 SHALL have mlp_values (out, sfp[inputs]), mlp_expected (out, sfp[outputs]), mlp_training (out, 1) and mlp_prediction (in, sfp[outputs]) as the MLP drive side.
REQ-009 SHALL have sample_index (out, 16), epoch_count (out, 16), result_valid (out, 1), result_prediction (out, sfp[outputs]) and epoch_loss (out, sfp).

Function
REQ-010 SHALL write sample memory on a clk edge when wr_en=1 and busy=0; writes while busy=1 are dropped.
REQ-011 SHALL use the FSM states IDLE, APPLY, TRAIN, ADVANCE and DONE.
REQ-012 SHALL move IDLE->APPLY on start=1, with sample_index=0 and epoch_count=0; start outside IDLE is ignored.
REQ-013 SHALL move IDLE->DONE instead when start=1 and either num_samples=0 or num_epochs=0; no mlp_training pulse occurs in that case.
REQ-014 SHALL use effective sample count N = min(num_samples, depth), latched together with num_epochs (E) at start.
REQ-015 SHALL stay in APPLY for exactly settle_cycles cycles, driving mlp_values/mlp_expected from memory[sample_index] with mlp_training=0.
REQ-016 SHALL stay in TRAIN for exactly one cycle with mlp_training=1; the MLP applies weight updates on that cycle's closing edge.
REQ-017 SHALL capture mlp_prediction into result_prediction on the TRAIN->ADVANCE edge, and SHALL hold result_valid=1 for the ADVANCE cycle only.
REQ-018 In ADVANCE, SHALL go to APPLY with sample_index+1 if sample_index<N-1; otherwise SHALL wrap sample_index to 0 and increment epoch_count.
REQ-019 In ADVANCE, SHALL go to DONE when the incremented epoch_count equals E, otherwise to APPLY.
REQ-020 SHALL stay in DONE for one cycle with done=1, then return to IDLE.
REQ-021 SHALL assert busy in every state except IDLE.
REQ-022 SHALL assert done exactly N*E*(settle_cycles+2) edges after the edge that sampled start.
REQ-023 SHALL hold mlp_values and mlp_expected stable from the start of APPLY through the end of TRAIN.
REQ-024 SHALL hold sample_index and epoch_count after DONE until the next accepted start.

Reset
REQ-025 On rst=1, SHALL force state IDLE and drive busy, done, mlp_training and result_valid to 0 immediately, without waiting for clk.
REQ-026 On rst=1, SHALL clear sample_index, epoch_count, result_prediction, epoch_loss, mlp_values and mlp_expected to 0.
REQ-027 SHALL NOT reset sample memory; rst mid-run aborts the run without a done pulse.

Configuration
REQ-028 With MLP_TRAINER_LOSS_EN defined, SHALL accumulate the sum over outputs of |mlp_prediction-mlp_expected| on each TRAIN->ADVANCE edge, using sfp_add saturating at SFP_MAX.
REQ-029 With MLP_TRAINER_LOSS_EN defined, SHALL copy the accumulator to epoch_loss at each epoch boundary and then clear the accumulator.
REQ-030 Without MLP_TRAINER_LOSS_EN, SHALL omit the accumulator logic and tie epoch_loss to 0.

Structure
REQ-031 SHALL take sfp, sfp_add, sfp_sub and ONE from package FixedPoint, and SHALL add SFP_MAX to that package.
REQ-032 SHALL declare the typedef enum trainer_state_t in package Common.
REQ-033 SHALL implement sample storage as one sub-module, mlp_sample_mem (synchronous write, combinational read).

Verification
REQ-034 inputs=2, settle_cycles=2; load the 4 XOR samples; N=4, E=1 -> 4 mlp_training pulses, done 16 edges after start, result_valid 4 times.
REQ-035 num_samples=9, depth=4, E=2 -> sample_index sequence 0,1,2,3,0,1,2,3, epoch_count ends at 2, done 32 edges after start.
REQ-036 num_epochs=0 with start -> done one cycle later, mlp_training never asserted.
REQ-037 rst asserted in the middle of TRAIN -> mlp_training and busy go to 0 asynchronously, no done pulse, previously loaded memory still readable on the next run.
REQ-038 With MLP_TRAINER_LOSS_EN defined, a stub MLP returns prediction 0.5 for expected 1.0 on every sample; N=2 -> epoch_loss=1.0 after epoch 1.
REQ-039 wr_en pulsed and start pulsed again while busy -> memory unchanged and run timing unchanged.
